// File: rtl/fire_pkg.sv
// Shared types and constants for the fire-protection sensor front end.
// Channel FSM states and the fail-safe levels driven while a sensor is stale.
package fire_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RISING  = 2'd1,
        ACTIVE  = 2'd2,
        FALLING = 2'd3
    } ch_state_t;

    localparam logic HEAT_FAILSAFE  = 1'b0;
    localparam logic SMOKE_FAILSAFE = 1'b1;

endpackage

// File: rtl/sensor_channel.sv
// One sensor channel: hysteresis thresholds, persistence filter, stale watchdog.
// Output is registered; the state only moves on cycles where i_valid is high.
import fire_pkg::*;

module sensor_channel #(
    parameter int   DATA_W       = 12,
    parameter int   ON           = 600,
    parameter int   OFF          = 550,
    parameter int   PERSIST      = 4,
    parameter int   STALE_CYCLES = 1000,
    parameter logic FAILSAFE     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_signal,
    output logic              o_fault
);

    localparam int IDLE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] STALE_MAX = IDLE_W'(STALE_CYCLES);
    localparam logic [DATA_W-1:0] ON_V      = DATA_W'(ON);
    localparam logic [DATA_W-1:0] OFF_V     = DATA_W'(OFF);
    localparam logic [3:0]        PERSIST_V = 4'(PERSIST);

    ch_state_t         r_state;
    ch_state_t         w_state_nxt;
    ch_state_t         w_base_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [3:0]        w_base_cnt;
    logic [3:0]        w_cnt_inc;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_nxt;
    logic              r_fault;
    logic              w_fault_nxt;
    logic              r_out;
    logic              w_out_nxt;
    logic              w_hi;
    logic              w_lo;

    assign w_hi = (i_data >= ON_V);
    assign w_lo = (i_data <= OFF_V);

    // A sample arriving while faulted is judged as if the FSM had just been reset.
    assign w_base_state = r_fault ? CLEAR : r_state;
    assign w_base_cnt   = r_fault ? 4'd0  : r_cnt;
    assign w_cnt_inc    = w_base_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_valid) begin
            w_state_nxt = w_base_state;
            w_cnt_nxt   = w_base_cnt;
            case (w_base_state)
                CLEAR: begin
                    if (w_hi) begin
                        w_state_nxt = RISING;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                RISING: begin
                    if (!w_hi) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = 4'd0;
                    end else if (w_cnt_inc == PERSIST_V) begin
                        w_state_nxt = ACTIVE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                ACTIVE: begin
                    if (w_lo) begin
                        w_state_nxt = FALLING;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                FALLING: begin
                    if (!w_lo) begin
                        w_state_nxt = ACTIVE;
                        w_cnt_nxt   = 4'd0;
                    end else if (w_cnt_inc == PERSIST_V) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_idle_nxt = r_idle;
        if (i_valid) begin
            w_idle_nxt = '0;
        end else if (r_idle != STALE_MAX) begin
            w_idle_nxt = r_idle + 1'b1;
        end
    end

    assign w_fault_nxt = (w_idle_nxt == STALE_MAX);
    assign w_out_nxt   = w_fault_nxt ? FAILSAFE
                                     : ((w_state_nxt == ACTIVE) || (w_state_nxt == FALLING));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= 4'd0;
            r_idle  <= '0;
            r_fault <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idle  <= w_idle_nxt;
            r_fault <= w_fault_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign o_signal = r_out;
    assign o_fault  = r_fault;

endmodule

// File: rtl/fire_sensor_conditioner.sv
// Conditions raw temperature and smoke samples into clean heat/smoke levels.
// Two independent channels; all outputs registered, no input-to-output paths.
import fire_pkg::*;

module fire_sensor_conditioner #(
    parameter int DATA_W       = 12,
    parameter int HEAT_ON      = 600,
    parameter int HEAT_OFF     = 550,
    parameter int SMOKE_ON     = 300,
    parameter int SMOKE_OFF    = 250,
    parameter int PERSIST      = 4,
    parameter int STALE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [DATA_W-1:0] temp_data,
    input  logic              smoke_valid,
    input  logic [DATA_W-1:0] smoke_data,
    output logic              heat_signal,
    output logic              smoke_signal,
    output logic [1:0]        sensor_fault
);

    logic w_temp_fault;
    logic w_smoke_fault;

    sensor_channel #(
        .DATA_W       (DATA_W),
        .ON           (HEAT_ON),
        .OFF          (HEAT_OFF),
        .PERSIST      (PERSIST),
        .STALE_CYCLES (STALE_CYCLES),
        .FAILSAFE     (HEAT_FAILSAFE)
    ) u_temp_ch (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (temp_valid),
        .i_data   (temp_data),
        .o_signal (heat_signal),
        .o_fault  (w_temp_fault)
    );

    sensor_channel #(
        .DATA_W       (DATA_W),
        .ON           (SMOKE_ON),
        .OFF          (SMOKE_OFF),
        .PERSIST      (PERSIST),
        .STALE_CYCLES (STALE_CYCLES),
        .FAILSAFE     (SMOKE_FAILSAFE)
    ) u_smoke_ch (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (smoke_valid),
        .i_data   (smoke_data),
        .o_signal (smoke_signal),
        .o_fault  (w_smoke_fault)
    );

    assign sensor_fault = {w_smoke_fault, w_temp_fault};

endmodule

// File: tb/tb_fire_sensor_conditioner.sv
// Directed bench for fire_sensor_conditioner with a shortened stale timeout.
module tb_fire_sensor_conditioner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        temp_valid = 1'b0;
    logic [11:0] temp_data = '0;
    logic        smoke_valid = 1'b0;
    logic [11:0] smoke_data = '0;
    logic        heat_signal;
    logic        smoke_signal;
    logic [1:0]  sensor_fault;

    int total  = 0;
    int passed = 0;

    fire_sensor_conditioner #(
        .DATA_W       (12),
        .HEAT_ON      (600),
        .HEAT_OFF     (550),
        .SMOKE_ON     (300),
        .SMOKE_OFF    (250),
        .PERSIST      (4),
        .STALE_CYCLES (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .temp_valid   (temp_valid),
        .temp_data    (temp_data),
        .smoke_valid  (smoke_valid),
        .smoke_data   (smoke_data),
        .heat_signal  (heat_signal),
        .smoke_signal (smoke_signal),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: inputs set at a falling edge, captured at the next rising edge.
    task automatic step(input logic tv, input logic [11:0] td,
                        input logic sv, input logic [11:0] sd);
        temp_valid  = tv;
        temp_data   = td;
        smoke_valid = sv;
        smoke_data  = sd;
        @(negedge clk);
        temp_valid  = 1'b0;
        smoke_valid = 1'b0;
    endtask

    task automatic temp_n(input int n, input logic [11:0] v);
        for (int i = 0; i < n; i++) step(1'b1, v, 1'b0, 12'd0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'd0, 1'b0, 12'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("reset_heat",  heat_signal,  0);
        chk("reset_smoke", smoke_signal, 0);
        chk("reset_fault", sensor_fault, 0);

        // Persistence on
        temp_n(3, 12'd650);
        chk("persist_3", heat_signal, 0);
        temp_n(1, 12'd650);
        chk("persist_4", heat_signal, 1);

        // Interrupted run
        do_reset();
        temp_n(2, 12'd650);
        temp_n(1, 12'd580);
        temp_n(3, 12'd650);
        chk("interrupt_3", heat_signal, 0);
        temp_n(1, 12'd650);
        chk("interrupt_4", heat_signal, 1);

        // Hysteresis
        temp_n(10, 12'd560);
        chk("hyst_mid", heat_signal, 1);
        temp_n(3, 12'd540);
        chk("hyst_fall_3", heat_signal, 1);
        temp_n(1, 12'd540);
        chk("hyst_fall_4", heat_signal, 0);
        temp_n(4, 12'd650);
        chk("hyst_rearm", heat_signal, 1);
        temp_n(2, 12'd540);
        temp_n(1, 12'd570);
        chk("hyst_abort_fall", heat_signal, 1);
        temp_n(4, 12'd540);
        chk("hyst_after_abort", heat_signal, 0);

        // Threshold boundaries: exactly ON qualifies, ON-1 does not; exactly OFF qualifies
        do_reset();
        temp_n(6, 12'd599);
        chk("below_on", heat_signal, 0);
        temp_n(4, 12'd600);
        chk("at_on", heat_signal, 1);
        temp_n(3, 12'd550);
        chk("at_off_3", heat_signal, 1);
        temp_n(1, 12'd550);
        chk("at_off_4", heat_signal, 0);

        // Sparse valid smoke
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 12'd0, 1'b1, 12'd320);
            idle_n(4);
        end
        chk("sparse_3", smoke_signal, 0);
        step(1'b0, 12'd0, 1'b1, 12'd320);
        chk("sparse_4", smoke_signal, 1);

        // Simultaneous samples on both channels
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 12'd650, 1'b1, 12'd400);
        chk("both_heat",  heat_signal,  1);
        chk("both_smoke", smoke_signal, 1);

        // Stale fault
        do_reset();
        idle_n(63);
        chk("stale_63_fault", sensor_fault, 2'b00);
        chk("stale_63_smoke", smoke_signal, 0);
        idle_n(1);
        chk("stale_64_fault", sensor_fault, 2'b11);
        chk("stale_64_smoke", smoke_signal, 1);
        chk("stale_64_heat",  heat_signal,  0);
        step(1'b0, 12'd0, 1'b1, 12'd100);
        chk("recover_smoke_fault", sensor_fault, 2'b01);
        chk("recover_smoke",       smoke_signal, 0);
        step(1'b1, 12'd650, 1'b0, 12'd0);
        chk("recover_temp_fault", sensor_fault, 2'b00);
        chk("recover_temp_heat",  heat_signal,  0);
        temp_n(3, 12'd650);
        chk("recover_temp_on", heat_signal, 1);

        // Reset mid-run
        do_reset();
        temp_n(3, 12'd650);
        do_reset();
        temp_n(1, 12'd650);
        chk("midreset_1", heat_signal, 0);
        temp_n(2, 12'd650);
        chk("midreset_3", heat_signal, 0);
        temp_n(1, 12'd650);
        chk("midreset_4", heat_signal, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
